fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have a single clock clk (rising edge) and reset rst_n, asynchronous, active-low.
REQ-002 Ports SHALL be, one per line:
  clk  in  1  system clock
  rst_n  in  1  async active-low reset
  F_stall  in  1  hold predicted-PC register
  D_stall  in  1  hold decode register
  D_bubble  in  1  load nop into decode register
  M_icode  in  4  memory-stage icode (mispredict detect)
  M_cnd  in  1  memory-stage branch condition
  M_valA  in  64  fall-through PC of mispredicted jXX
  W_icode  in  4  writeback-stage icode (ret detect)
  W_valM  in  64  return address from ret
  imem_addr  out  64  fetch address (= f_pc)
  imem_rdata  in  80  10 bytes at imem_addr, byte0 in [7:0], combinational
  imem_err  in  1  address invalid (used only under FETCH_IMEM_CHK_EN)
  F_predPC  out  64  predicted-PC register
  D_stat, D_icode, D_ifun, D_rA, D_rB  out  3/4/4/4/4  decode register fields
  D_valC, D_valP  out  64/64  decode register constants
  halted  out  1  fetch frozen after HLT/ADR/INS

Function
REQ-003 f_pc SHALL be M_valA if M_icode==7 and !M_cnd; else W_valM if W_icode==9; else F_predPC.
REQ-004 icode=byte0[7:4], ifun=byte0[3:0]; rA=byte1[7:4], rB=byte1[3:0] when need_regids, else both 4'hF.
REQ-005 need_regids SHALL be true for icodes 2,3,4,5,6,A,B; need_valC for 3,4,5,7,8.
REQ-006 valC SHALL be little-endian bytes 2..9 if need_regids, else bytes 1..8; 0 when !need_valC.
REQ-007 valP SHALL be f_pc + 1 + need_regids + 8*need_valC, 64-bit modulo (wrap, no flag).
REQ-008 Predicted PC SHALL be valC for icode 7 or 8, valP otherwise.
REQ-009 Fetch stat: INS if icode > 4'hB; HLT if icode==0; else AOK (ADR per REQ-016).
REQ-010 On rising clk, unless F_stall or halted, F_predPC SHALL load predicted PC.
REQ-011 On rising clk: D_bubble loads nop (stat AOK, icode 1, ifun 0, rA=rB=F, valC=valP=0); else !D_stall loads fetched fields; D_bubble overrides D_stall.
REQ-012 Two states RUN/HALT: RUN->HALT on any clock where fetched stat!=AOK and decode register loads; HALT holds until reset; halted=1 in HALT.
REQ-013 In HALT, the decode register SHALL load bubbles regardless of D_stall (D_bubble behaviour unchanged); F_predPC frozen.
REQ-014 A mispredict/ret redirect in the same cycle as F_stall SHALL still drive imem_addr from REQ-003; only register updates are gated.

Reset
REQ-015 rst_n low SHALL immediately force F_predPC=0, state RUN, halted=0, decode register to nop bubble; reset mid-stall SHALL discard all held state.

Configuration
REQ-016 With FETCH_IMEM_CHK_EN defined, imem_err=1 SHALL give fetch stat ADR (priority over INS/HLT) and force icode to 1; without it, imem_err SHALL be ignored and ADR never produced.

Structure
REQ-017 Package y86_pkg SHALL hold icode constants (IHALT..IPOPQ), stat encodings (AOK=1, HLT=2, ADR=3, INS=4), RNONE=4'hF, and the decode-register struct typedef.
REQ-018 One sub-module, fetch_split (combinational byte split, need_* decode, valC/valP); registers and state machine stay in fetch_stage.

Verification
REQ-019 Directed scenarios SHALL include:
  - irmovq at PC 0 (bytes 30 F2 08 00..00) -> D_icode 3, D_rB 2, D_valC 8, D_valP 10, F_predPC 10.
  - jXX at PC 0x20 target 0x100 -> F_predPC 0x100; next cycle M_icode 7, M_cnd 0, M_valA 0x29 -> imem_addr 0x29.
  - W_icode 9, W_valM 0x44 -> imem_addr 0x44 regardless of F_predPC.
  - F_stall=1, D_stall=1 for 3 cycles -> F_predPC and D_* unchanged; D_bubble=1 with D_stall=1 -> D_icode 1.
  - Byte0 0x00 -> D_stat HLT, halted=1 next cycle, F_predPC frozen; byte0 0xC0 -> D_stat INS.
  - FETCH_IMEM_CHK_EN: imem_err=1 -> D_stat ADR, D_icode 1; rst_n pulse mid-run -> F_predPC 0, halted 0.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions for the fetch slice: icodes, stat codes,
// register-none marker and the decode pipeline register layout.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RNONE   = 4'hF;

  typedef enum logic [2:0] {
    AOK = 3'd1,
    HLT = 3'd2,
    ADR = 3'd3,
    INS = 3'd4
  } stat_e;

  typedef enum logic {
    S_RUN,
    S_HALT
  } fetch_state_e;

  typedef struct packed {
    stat_e       stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic [63:0] valC;
    logic [63:0] valP;
  } d_reg_t;

  localparam d_reg_t D_NOP = '{
    stat:  AOK,
    icode: INOP,
    ifun:  4'h0,
    rA:    RNONE,
    rB:    RNONE,
    valC:  64'h0,
    valP:  64'h0
  };

endpackage

// File: rtl/fetch_split.sv
// Combinational instruction split: opcode fields, register ids,
// constant word and fall-through PC from the 10 fetched bytes.
module fetch_split
  import y86_pkg::*;
(
  input  logic [63:0] pc_i,
  input  logic [79:0] bytes_i,
  output logic [3:0]  icode_o,
  output logic [3:0]  ifun_o,
  output logic [3:0]  rA_o,
  output logic [3:0]  rB_o,
  output logic [63:0] valC_o,
  output logic [63:0] valP_o
);

  logic need_regids;
  logic need_valC;

  // Decode which optional instruction parts are present and extract them
  always_comb begin
    icode_o     = bytes_i[7:4];
    ifun_o      = bytes_i[3:0];
    need_regids = 1'b0;
    need_valC   = 1'b0;
    case (bytes_i[7:4])
      IRRMOVQ, IOPQ, IPUSHQ, IPOPQ: need_regids = 1'b1;
      IIRMOVQ, IRMMOVQ, IMRMOVQ: begin
        need_regids = 1'b1;
        need_valC   = 1'b1;
      end
      IJXX, ICALL: need_valC = 1'b1;
      default: ;
    endcase
    rA_o   = need_regids ? bytes_i[15:12] : RNONE;
    rB_o   = need_regids ? bytes_i[11:8]  : RNONE;
    valC_o = '0;
    if (need_valC) valC_o = need_regids ? bytes_i[79:16] : bytes_i[71:8];
    valP_o = pc_i + 64'd1 + {63'd0, need_regids} + {60'd0, need_valC, 3'd0};
  end

endmodule

// File: rtl/fetch_stage.sv
// Y86-64 fetch stage: PC selection, predicted-PC register, decode pipeline
// register and RUN/HALT freeze. Define FETCH_IMEM_CHK_EN to turn imem_err
// into an ADR fetch status.
module fetch_stage
  import y86_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        F_stall,
  input  logic        D_stall,
  input  logic        D_bubble,
  input  logic [3:0]  M_icode,
  input  logic        M_cnd,
  input  logic [63:0] M_valA,
  input  logic [3:0]  W_icode,
  input  logic [63:0] W_valM,
  output logic [63:0] imem_addr,
  input  logic [79:0] imem_rdata,
  input  logic        imem_err,
  output logic [63:0] F_predPC,
  output logic [2:0]  D_stat,
  output logic [3:0]  D_icode,
  output logic [3:0]  D_ifun,
  output logic [3:0]  D_rA,
  output logic [3:0]  D_rB,
  output logic [63:0] D_valC,
  output logic [63:0] D_valP,
  output logic        halted
);

  logic [63:0]  f_pc;
  logic [63:0]  predpc_q, predpc_d, f_predpc;
  logic [3:0]   s_icode, s_ifun, s_rA, s_rB;
  logic [63:0]  s_valC, s_valP;
  logic [3:0]   f_icode;
  stat_e        f_stat;
  d_reg_t       f_fields;
  d_reg_t       d_q, d_d;
  fetch_state_e state_q, state_d;

  // Select fetch address: mispredicted branch, then ret, then prediction
  always_comb begin
    if (M_icode == IJXX && !M_cnd) f_pc = M_valA;
    else if (W_icode == IRET)      f_pc = W_valM;
    else                           f_pc = predpc_q;
  end

  assign imem_addr = f_pc;

  fetch_split u_split (
    .pc_i    (f_pc),
    .bytes_i (imem_rdata),
    .icode_o (s_icode),
    .ifun_o  (s_ifun),
    .rA_o    (s_rA),
    .rB_o    (s_rB),
    .valC_o  (s_valC),
    .valP_o  (s_valP)
  );

`ifndef FETCH_IMEM_CHK_EN
  logic unused_imem_err;
  assign unused_imem_err = imem_err;
`endif

  // Fetch status, effective icode and next-PC prediction
  always_comb begin
    f_icode = s_icode;
    if (s_icode > IPOPQ)       f_stat = INS;
    else if (s_icode == IHALT) f_stat = HLT;
    else                       f_stat = AOK;
`ifdef FETCH_IMEM_CHK_EN
    if (imem_err) begin
      f_stat  = ADR;
      f_icode = INOP;
    end
`endif
    f_predpc = (f_icode == IJXX || f_icode == ICALL) ? s_valC : s_valP;
    f_fields = '{stat: f_stat, icode: f_icode, ifun: s_ifun, rA: s_rA,
                 rB: s_rB, valC: s_valC, valP: s_valP};
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_RUN;
    else        state_q <= state_d;
  end

  // FSM next state: freeze once a non-AOK instruction enters decode
  always_comb begin
    state_d = state_q;
    if (state_q == S_RUN && f_stat != AOK && !D_bubble && !D_stall)
      state_d = S_HALT;
  end

  // FSM outputs
  always_comb begin
    halted = (state_q == S_HALT);
  end

  // Predicted-PC next value, held on stall or after halt
  always_comb begin
    predpc_d = predpc_q;
    if (!F_stall && !halted) predpc_d = f_predpc;
  end

  // Predicted-PC register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) predpc_q <= '0;
    else        predpc_q <= predpc_d;
  end

  // Decode register next value: bubble wins over stall, halt forces bubbles
  always_comb begin
    d_d = d_q;
    if (D_bubble || halted) d_d = D_NOP;
    else if (!D_stall)      d_d = f_fields;
  end

  // Decode register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_q <= D_NOP;
    else        d_q <= d_d;
  end

  assign F_predPC = predpc_q;
  assign D_stat   = d_q.stat;
  assign D_icode  = d_q.icode;
  assign D_ifun   = d_q.ifun;
  assign D_rA     = d_q.rA;
  assign D_rB     = d_q.rB;
  assign D_valC   = d_q.valC;
  assign D_valP   = d_q.valP;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: constant table, directed sequences
// and randomized traffic against a byte-level instruction model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        F_stall = 1'b0, D_stall = 1'b0, D_bubble = 1'b0;
  logic [3:0]  M_icode = '0, W_icode = '0;
  logic        M_cnd = 1'b0;
  logic [63:0] M_valA = '0, W_valM = '0;
  logic [63:0] imem_addr;
  logic [79:0] imem_rdata;
  logic        imem_err = 1'b0;
  logic [63:0] F_predPC, D_valC, D_valP;
  logic [2:0]  D_stat;
  logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
  logic        halted;

  int total = 0;
  int bad = 0;

`ifdef FETCH_IMEM_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  // icode membership sets, bit n set when icode n has the part
  localparam logic [15:0] HAS_REGS = 16'h0C7C;
  localparam logic [15:0] HAS_CONST = 16'h01B8;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .F_stall(F_stall), .D_stall(D_stall),
    .D_bubble(D_bubble), .M_icode(M_icode), .M_cnd(M_cnd), .M_valA(M_valA),
    .W_icode(W_icode), .W_valM(W_valM), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_err(imem_err), .F_predPC(F_predPC),
    .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA),
    .D_rB(D_rB), .D_valC(D_valC), .D_valP(D_valP), .halted(halted)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:4095];

  always_comb begin
    imem_rdata = '0;
    for (int i = 0; i < 10; i++)
      imem_rdata[8*i +: 8] = mem[imem_addr[11:0] + 12'(i)];
  end

  typedef struct {
    logic [2:0]  stat;
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc, valp;
  } dfields_t;

  localparam dfields_t M_NOP = '{3'd1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0};

  logic [63:0] m_pc;
  logic        m_halt;
  dfields_t    m_d;

  function automatic logic [7:0] rd(input logic [63:0] a);
    return mem[a[11:0]];
  endfunction

  // Instruction at pc interpreted from its byte layout
  function automatic void fetch_model(input logic [63:0] pc, input logic err,
                                      output dfields_t f, output logic [63:0] pred);
    logic [7:0]  b0;
    logic        has_r, has_c;
    int unsigned pos;
    b0 = rd(pc);
    has_r = HAS_REGS[b0[7:4]];
    has_c = HAS_CONST[b0[7:4]];
    f.icode = b0[7:4];
    f.ifun  = b0[3:0];
    f.ra = has_r ? rd(pc + 1) >> 4 : 8'h0F;
    f.rb = has_r ? rd(pc + 1) & 8'h0F : 8'h0F;
    pos = has_r ? 2 : 1;
    f.valc = 0;
    if (has_c)
      for (int k = 0; k < 8; k++)
        f.valc = f.valc + (64'(rd(pc + 64'(pos) + 64'(k))) << (8 * k));
    f.valp = pc + 1 + (has_r ? 1 : 0) + (has_c ? 8 : 0);
    if (f.icode == 0)      f.stat = 3'd2;
    else if (f.icode > 11) f.stat = 3'd4;
    else                   f.stat = 3'd1;
    if (CHK && err) begin
      f.stat  = 3'd3;
      f.icode = 4'h1;
    end
    pred = (f.icode == 7 || f.icode == 8) ? f.valc : f.valp;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_state();
    chk("F_predPC", F_predPC, m_pc);
    chk("D_stat", 64'(D_stat), 64'(m_d.stat));
    chk("D_icode", 64'(D_icode), 64'(m_d.icode));
    chk("D_ifun", 64'(D_ifun), 64'(m_d.ifun));
    chk("D_rA", 64'(D_rA), 64'(m_d.ra));
    chk("D_rB", 64'(D_rB), 64'(m_d.rb));
    chk("D_valC", D_valC, m_d.valc);
    chk("D_valP", D_valP, m_d.valp);
    chk("halted", 64'(halted), 64'(m_halt));
  endtask

  task automatic idle();
    F_stall = 0; D_stall = 0; D_bubble = 0; M_icode = 0; M_cnd = 0;
    M_valA = 0; W_icode = 0; W_valM = 0; imem_err = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    m_pc = 0; m_halt = 0; m_d = M_NOP;
    check_state();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // One clock with the currently applied inputs, model advanced alongside
  task automatic cycle();
    logic [63:0] fpc, pred;
    dfields_t    f;
    if (M_icode == 7 && !M_cnd) fpc = M_valA;
    else if (W_icode == 9)      fpc = W_valM;
    else                        fpc = m_pc;
    #1;
    chk("imem_addr", imem_addr, fpc);
    fetch_model(fpc, imem_err, f, pred);
    @(posedge clk); #1;
    if (!F_stall && !m_halt) m_pc = pred;
    if (!m_halt && f.stat != 3'd1 && !D_bubble && !D_stall) begin
      m_halt = 1;
      m_d = f;
    end else if (D_bubble || m_halt) m_d = M_NOP;
    else if (!D_stall) m_d = f;
    check_state();
  endtask

  task automatic put(input logic [63:0] a, input logic [79:0] d, input int n);
    for (int k = 0; k < n; k++) mem[a[11:0] + 12'(k)] = d[8*k +: 8];
  endtask

  task automatic fill_nop();
    for (int a = 0; a < 4096; a++) mem[a] = 8'h10;
  endtask

  typedef struct {
    logic [79:0] bytes;
    logic [2:0]  stat;
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc, valp, pred;
    logic        halt;
  } vec_t;

  vec_t vt[10];

  initial begin
    vt[0] = '{80'h0000000000000008F230, 3'd1, 4'h3, 4'h0, 4'hF, 4'h2, 64'h8, 64'd10, 64'd10, 1'b0};
    vt[1] = '{80'h00000000000000010070, 3'd1, 4'h7, 4'h0, 4'hF, 4'hF, 64'h100, 64'd9, 64'h100, 1'b0};
    vt[2] = '{80'h00000000000000002360, 3'd1, 4'h6, 4'h0, 4'h2, 4'h3, 64'h0, 64'd2, 64'd2, 1'b0};
    vt[3] = '{80'h00000000000000123480, 3'd1, 4'h8, 4'h0, 4'hF, 4'hF, 64'h1234, 64'd9, 64'h1234, 1'b0};
    vt[4] = '{80'h00000000000000000090, 3'd1, 4'h9, 4'h0, 4'hF, 4'hF, 64'h0, 64'd1, 64'd1, 1'b0};
    vt[5] = '{80'hFFFFFFFFFFFFFFF01550, 3'd1, 4'h5, 4'h0, 4'h1, 4'h5, 64'hFFFFFFFFFFFFFFF0, 64'd10, 64'd10, 1'b0};
    vt[6] = '{80'h00000000000000001221, 3'd1, 4'h2, 4'h1, 4'h1, 4'h2, 64'h0, 64'd2, 64'd2, 1'b0};
    vt[7] = '{80'h000000000000000000C0, 3'd4, 4'hC, 4'h0, 4'hF, 4'hF, 64'h0, 64'd1, 64'd1, 1'b1};
    vt[8] = '{80'h00000000000000000000, 3'd2, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'd1, 64'd1, 1'b1};
    vt[9] = '{80'h00000000000000002FA0, 3'd1, 4'hA, 4'h0, 4'h2, 4'hF, 64'h0, 64'd2, 64'd2, 1'b0};

    fill_nop();
    idle();
    @(posedge clk); #1;

    // Table: single instruction at PC 0 straight after reset
    for (int i = 0; i < 10; i++) begin
      fill_nop();
      put(0, vt[i].bytes, 10);
      do_reset();
      idle();
      @(posedge clk); #1;
      chk("tbl F_predPC", F_predPC, vt[i].pred);
      chk("tbl D_stat", 64'(D_stat), 64'(vt[i].stat));
      chk("tbl D_icode", 64'(D_icode), 64'(vt[i].icode));
      chk("tbl D_ifun", 64'(D_ifun), 64'(vt[i].ifun));
      chk("tbl D_rA", 64'(D_rA), 64'(vt[i].ra));
      chk("tbl D_rB", 64'(D_rB), 64'(vt[i].rb));
      chk("tbl D_valC", D_valC, vt[i].valc);
      chk("tbl D_valP", D_valP, vt[i].valp);
      chk("tbl halted", 64'(halted), 64'(vt[i].halt));
    end

    // Jump to 0x20, conditional jump predicted to 0x100, then redirects
    fill_nop();
    put(0, 80'h00000000000000002070, 9);
    put(64'h20, 80'h00000000000000010074, 9);
    idle();
    do_reset();
    cycle();
    chk("jmp predPC", F_predPC, 64'h20);
    cycle();
    chk("jXX predPC", F_predPC, 64'h100);
    M_icode = 4'h7; M_cnd = 1'b0; M_valA = 64'h29; F_stall = 1'b1;
    #1;
    chk("mispredict addr", imem_addr, 64'h29);
    cycle();
    chk("mispredict stall predPC", F_predPC, 64'h100);
    idle();
    W_icode = 4'h9; W_valM = 64'h44;
    #1;
    chk("ret addr", imem_addr, 64'h44);
    cycle();
    chk("ret predPC", F_predPC, 64'h45);

    // Both stalls held three cycles, then bubble over stall
    idle();
    F_stall = 1'b1; D_stall = 1'b1;
    repeat (3) cycle();
    chk("stall predPC", F_predPC, 64'h45);
    chk("stall D_valP", D_valP, 64'h45);
    D_bubble = 1'b1;
    cycle();
    chk("bubble D_icode", 64'(D_icode), 64'h1);
    chk("bubble D_valP", D_valP, 64'h0);

    // Halt at PC 1, freeze, then asynchronous reset while stalled
    idle();
    fill_nop();
    put(0, 80'h0010, 2);
    do_reset();
    cycle();
    chk("pre-halt predPC", F_predPC, 64'h1);
    cycle();
    chk("halt D_stat", 64'(D_stat), 64'h2);
    chk("halt flag", 64'(halted), 64'h1);
    chk("halt predPC", F_predPC, 64'h2);
    repeat (2) cycle();
    chk("frozen predPC", F_predPC, 64'h2);
    chk("frozen D_icode", 64'(D_icode), 64'h1);
    F_stall = 1'b1; D_stall = 1'b1;
    #3;
    do_reset();
    chk("reset predPC", F_predPC, 64'h0);
    chk("reset halted", 64'(halted), 64'h0);

    // Instruction-memory error flag
    idle();
    fill_nop();
    do_reset();
    imem_err = 1'b1;
    cycle();
`ifdef FETCH_IMEM_CHK_EN
    chk("imem_err D_stat", 64'(D_stat), 64'h3);
    chk("imem_err D_icode", 64'(D_icode), 64'h1);
    chk("imem_err halted", 64'(halted), 64'h1);
`else
    chk("imem_err D_stat", 64'(D_stat), 64'h1);
    chk("imem_err halted", 64'(halted), 64'h0);
`endif

    // Randomized traffic over random mostly-valid code
    idle();
    for (int a = 0; a < 4096; a++) begin
      int unsigned r;
      logic [3:0] hi;
      r = $urandom_range(0, 99);
      if (r < 3)      hi = 4'h0;
      else if (r < 6) hi = 4'(12 + $urandom_range(0, 3));
      else            hi = 4'($urandom_range(1, 11));
      mem[a] = {hi, 4'($urandom_range(0, 15))};
    end
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if (n % 50 == 49) begin
        #($urandom_range(1, 3));
        do_reset();
      end
      F_stall  = ($urandom_range(0, 4) == 0);
      D_stall  = ($urandom_range(0, 4) == 0);
      D_bubble = ($urandom_range(0, 9) == 0);
      M_icode  = ($urandom_range(0, 3) == 0) ? 4'h7 : 4'($urandom_range(0, 15));
      M_cnd    = 1'($urandom_range(0, 1));
      M_valA   = {32'($urandom), 32'($urandom)};
      W_icode  = ($urandom_range(0, 4) == 0) ? 4'h9 : 4'($urandom_range(0, 15));
      W_valM   = {32'($urandom), 32'($urandom)};
      imem_err = ($urandom_range(0, 19) == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
